// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multi-cycle sequencer around a single-bit shift-left stage.
// Each op runs 0..WIDTH-1 single-bit SLL, ROL or Fibonacci LFSR steps, one per clock.
// Optional feature macro: SHIFT_SEQ_ABORT_EN (adds the abort input).
module shift_seq_ctrl #(
    parameter int unsigned     WIDTH = 16,
    parameter int unsigned     AW    = 4,
    parameter logic [WIDTH-1:0] TAPS = 16'hB400,
    parameter logic [WIDTH-1:0] SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] din,
    input  logic [AW-1:0]    amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_ROL  = 2'b01;
    localparam logic [1:0] OP_LFSR = 2'b10;
    localparam logic [1:0] OP_CONT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] w_reg_nxt;
    logic [AW-1:0]    r_cnt;
    logic [AW-1:0]    w_cnt_nxt;
    logic [1:0]       r_op;
    logic [1:0]       w_op_nxt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] w_dout_nxt;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_load;
    logic             w_abort;

`ifdef SHIFT_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // One single-bit step of the latched op applied to the working register.
    always_comb begin
        w_step = r_reg;
        case (r_op)
            OP_SLL:  w_step = {r_reg[WIDTH-2:0], 1'b0};
            OP_ROL:  w_step = {r_reg[WIDTH-2:0], r_reg[WIDTH-1]};
            default: w_step = {r_reg[WIDTH-2:0], ^(r_reg & TAPS)};
        endcase
    end

    // Operand selected at acceptance; all-zero LFSR loads are replaced by SEED to avoid lock-up.
    always_comb begin
        w_load = din;
        if (op == OP_CONT) begin
            w_load = r_reg;
        end else if (op == OP_LFSR && din == '0) begin
            w_load = SEED;
        end
    end

    // Next-state, datapath and output-next logic.
    always_comb begin
        w_state_nxt = r_state;
        w_reg_nxt   = r_reg;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_dout_nxt  = r_dout;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_op_nxt  = op;
                    w_reg_nxt = w_load;
                    w_cnt_nxt = amt;
                    if (amt == '0) begin
                        w_state_nxt = S_DONE;
                        w_dout_nxt  = w_load;
                    end else begin
                        w_state_nxt = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_reg_nxt = w_step;
                    w_cnt_nxt = r_cnt - AW'(1);
                    if (r_cnt == AW'(1)) begin
                        w_state_nxt = S_DONE;
                        w_dout_nxt  = w_step;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_reg   <= SEED;
            r_cnt   <= '0;
            r_op    <= OP_SLL;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_reg   <= w_reg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
            r_dout  <= w_dout_nxt;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign dout = r_dout;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: edge-indexed behavioural model plus directed vectors.
module tb_shift_seq_ctrl;

    localparam int unsigned W = 16;
    localparam logic [15:0] TAPS = 16'hB400;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] din;
    logic [3:0]  amt;
    logic        busy;
    logic        done;
    logic [15:0] dout;
`ifdef SHIFT_SEQ_ABORT_EN
    logic        abort_in;
    initial abort_in = 1'b0;
`endif

    shift_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort (abort_in),
`endif
        .op    (op),
        .din   (din),
        .amt   (amt),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Result of a whole op computed from the op definitions.
    function automatic logic [15:0] op_result(input logic [1:0] o, input logic [15:0] d,
                                               input logic [3:0] a, input logic [15:0] wreg);
        logic [31:0] rot;
        logic [15:0] r;
        case (o)
            2'b00: return d << a;
            2'b01: begin
                rot = {d, d} << a;
                return rot[31:16];
            end
            default: begin
                r = (o == 2'b11) ? wreg : ((d == 16'h0) ? SEED : d);
                for (int k = 0; k < int'(a); k++) r = {r[14:0], ^(r & TAPS)};
                return r;
            end
        endcase
    endfunction

    // Model: an op accepted at edge t is busy through edge t+amt, done at edge t+amt,
    // and the next start is only accepted from edge t+amt+2.
    int          m_cyc;
    int          m_done_edge;
    logic [15:0] m_reg;
    logic [15:0] m_dout;
    logic [15:0] m_pending;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc       = 0;
            m_done_edge = -1;
            m_reg       = SEED;
            m_dout      = 16'h0;
            m_pending   = 16'h0;
        end else begin
            m_cyc++;
            if (start && m_cyc > m_done_edge + 1) begin
                m_pending   = op_result(op, din, amt, m_reg);
                m_reg       = m_pending;
                m_done_edge = m_cyc + int'(amt);
            end
            if (m_cyc == m_done_edge) m_dout = m_pending;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", 32'(busy), 32'(m_cyc <= m_done_edge));
            check("done", 32'(done), 32'(m_cyc == m_done_edge));
            check("dout", 32'(dout), 32'(m_dout));
        end
    end

    // Issue one op and wait for done; checks latency and the literal result.
    task automatic do_op(input string name, input logic [1:0] o, input logic [15:0] d,
                         input logic [3:0] a, input logic [15:0] exp);
        int waited;
        start = 1'b1; op = o; din = d; amt = a;
        @(negedge clk);
        start = 1'b0; op = 2'b00; din = 16'hDEAD; amt = 4'hF;
        waited = 0;
        while (!done && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check({name, "_latency"}, 32'(waited), 32'(a));
        check({name, "_dout"}, 32'(dout), 32'(exp));
        @(negedge clk);
    endtask

    initial begin
        int ndone;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; din = 16'h0; amt = 4'h0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_dout", 32'(dout), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("sll_1_4",   2'b00, 16'h0001, 4'd4,  16'h0010);
        do_op("rol_8001",  2'b01, 16'h8001, 4'd1,  16'h0003);
        do_op("sll_8001",  2'b00, 16'h8001, 4'd1,  16'h0002);
        do_op("lfsr_ace1", 2'b10, 16'hACE1, 4'd1,  16'h59C3);
        do_op("lfsr_cont", 2'b11, 16'h1111, 4'd1,  16'hB387);
        do_op("lfsr_zero", 2'b10, 16'h0000, 4'd0,  16'hACE1);
        do_op("sll_zero",  2'b00, 16'h0000, 4'd0,  16'h0000);
        do_op("rol_max",   2'b01, 16'h1234, 4'd15, 16'h091A);
        do_op("sll_max",   2'b00, 16'hFFFF, 4'd15, 16'h8000);
        do_op("pass_rol0", 2'b01, 16'hBEEF, 4'd0,  16'hBEEF);
        do_op("lfsr_8",    2'b10, 16'h1234, 4'd8,  op_result(2'b10, 16'h1234, 4'd8, 16'h0));
        do_op("cont_5",    2'b11, 16'h0000, 4'd5,  op_result(2'b11, 16'h0, 4'd5, m_reg));

        // Start while busy is ignored: one done pulse, first op's result.
        start = 1'b1; op = 2'b00; din = 16'h00FF; amt = 4'd8;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; din = 16'h1234; amt = 4'd1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("ignored_ndone", 32'(ndone), 32'd1);
        check("ignored_dout", 32'(dout), 32'h0000FF00);

        // Asynchronous reset mid-SHIFT.
        start = 1'b1; op = 2'b00; din = 16'h00FF; amt = 4'd8;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("amid_busy", 32'(busy), 32'h0);
        check("amid_done", 32'(done), 32'h0);
        check("amid_dout", 32'(dout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("after_rst", 2'b11, 16'h0000, 4'd1, 16'h59C3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
